// File: rtl/dmem_rr_arbiter_if.sv
// Bus bundle between the core array / RAM macro and dmem_rr_arbiter.
// The arbiter connects through the slave modport; cores and RAM form the master side.
interface dmem_rr_arbiter_if #(
    parameter int NCORES = 4,
    parameter int AW     = 8,
    parameter int DW     = 8
);
    logic [NCORES-1:0]    req;
    logic [NCORES-1:0]    wren;
    logic [NCORES*AW-1:0] Address;
    logic [NCORES*DW-1:0] Din;
    logic [DW-1:0]        RAMq;
    logic [NCORES-1:0]    grant;
    logic [NCORES-1:0]    ack;
    logic [DW-1:0]        Dq;
    logic [AW-1:0]        RAMAddress;
    logic [DW-1:0]        RAMDin;
    logic                 RAMwren;
    logic                 busy;

    modport slave (
        input  req, wren, Address, Din, RAMq,
        output grant, ack, Dq, RAMAddress, RAMDin, RAMwren, busy
    );

    modport master (
        output req, wren, Address, Din, RAMq,
        input  grant, ack, Dq, RAMAddress, RAMDin, RAMwren, busy
    );
endinterface

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one byte-wide synchronous RAM port among NCORES cores.
// Optional broadcast-read merging is enabled by defining DMEM_ARB_BROADCAST_EN.
module dmem_rr_arbiter #(
    parameter int NCORES = 4,
    parameter int AW     = 8,
    parameter int DW     = 8
) (
    input  logic             clk,
    input  logic             rstn,
    dmem_rr_arbiter_if.slave bus
);
    localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NCORES-1:0] grant_q, grant_d;
    logic [NCORES-1:0] ack_q, ack_d;
    logic [DW-1:0]     dq_q, dq_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     din_q, din_d;
    logic              wren_q, wren_d;
    logic              busy_q, busy_d;

    logic              win_found_s;
    logic [PW-1:0]     win_idx_s;
    logic [AW-1:0]     sel_addr_s;
    logic [DW-1:0]     sel_din_s;
    logic              sel_wren_s;
    logic              bcast_s;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int unsigned b);
        int unsigned s;
        s = (32'(a) + b) % 32'(NCORES);
        return PW'(s);
    endfunction

    // Winner search: scan downward so the nearest requester at or after the pointer wins last.
    always_comb begin
        logic [PW-1:0] idx;
        logic          hit;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            idx         = wrap_add(ptr_q, i);
            hit         = bus.req[idx];
            win_idx_s   = hit ? idx : win_idx_s;
            win_found_s = win_found_s | hit;
        end
    end

    // AND-OR select of the winner's address, data and direction.
    always_comb begin
        sel_addr_s = '0;
        sel_din_s  = '0;
        sel_wren_s = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            sel_addr_s = sel_addr_s | ({AW{win_idx_s == PW'(i)}} & bus.Address[i*AW +: AW]);
            sel_din_s  = sel_din_s  | ({DW{win_idx_s == PW'(i)}} & bus.Din[i*DW +: DW]);
            sel_wren_s = sel_wren_s | ((win_idx_s == PW'(i)) & bus.wren[i]);
        end
    end

`ifdef DMEM_ARB_BROADCAST_EN
    // Broadcast read: every core reading the same address is served by one RAM access.
    always_comb begin
        bcast_s = (&bus.req) & ~(|bus.wren);
        for (int i = 1; i < NCORES; i++) begin
            bcast_s = bcast_s & (bus.Address[i*AW +: AW] == bus.Address[AW-1:0]);
        end
    end
`else
    assign bcast_s = 1'b0;
`endif

    // Next-state and next-output logic of the transaction sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        ack_d   = '0;
        dq_d    = dq_q;
        addr_d  = addr_q;
        din_d   = din_q;
        wren_d  = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bcast_s) begin
                    grant_d = '1;
                    addr_d  = bus.Address[AW-1:0];
                    din_d   = bus.Din[DW-1:0];
                    state_d = S_ACCESS;
                end else if (win_found_s) begin
                    grant_d = {{(NCORES-1){1'b0}}, 1'b1} << win_idx_s;
                    ptr_d   = wrap_add(win_idx_s, 32'd1);
                    addr_d  = sel_addr_s;
                    din_d   = sel_din_s;
                    wren_d  = sel_wren_s;
                    state_d = S_ACCESS;
                end else begin
                    grant_d = '0;
                    addr_d  = '0;
                    din_d   = '0;
                end
            end
            S_ACCESS: begin
                // RAMwren is only ever high here for a write, so it doubles as the direction flag.
                if (wren_q) begin
                    ack_d   = grant_q;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                dq_d    = bus.RAMq;
                ack_d   = grant_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                grant_d = '0;
                addr_d  = '0;
                din_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                addr_d  = '0;
                din_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any transaction without an ack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            dq_q    <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            dq_q    <= dq_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wren_q  <= wren_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.ack        = ack_q;
    assign bus.Dq         = dq_q;
    assign bus.RAMAddress = addr_q;
    assign bus.RAMDin     = din_q;
    assign bus.RAMwren    = wren_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Self-checking bench for dmem_rr_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level reference model.
module tb_dmem_rr_arbiter;
    localparam int NC = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rstn;
    logic fill_en;

    always #5 clk = ~clk;

    dmem_rr_arbiter_if #(.NCORES(NC), .AW(AW), .DW(DW)) bus ();

    dmem_rr_arbiter #(.NCORES(NC), .AW(AW), .DW(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    function automatic logic [7:0] init_val(input int a);
        return (a == 21) ? 8'h5A : (a == 32) ? 8'h99 : 8'((a * 37 + 11) & 255);
    endfunction

    // Synchronous RAM macro model
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        end else begin
            if (bus.RAMwren) ram[bus.RAMAddress] <= bus.RAMDin;
            bus.RAMq <= ram[bus.RAMAddress];
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: transaction-level view of the arbiter
    logic [7:0]    ref_mem [256];
    int            m_p, m_next, m_start, m_ack_cyc;
    bit            m_active, m_wr;
    logic [NC-1:0] m_grant;
    logic [7:0]    m_addr, m_din, m_dq, m_rdata;

    int rate_req = 0;
    int rate_wr  = 0;
    int span     = 16;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_p      = 0;
        m_dq     = 8'h00;
        m_next   = cyc + 1;
    endtask

    task automatic model_edge();
        bit bc;
        int w;
        cyc++;
        if (!rstn) begin
            model_reset();
            return;
        end
        if (m_active && m_wr && cyc == m_start + 1) ref_mem[m_addr] = m_din;
        if (m_active && !m_wr && cyc == m_start + 1) m_rdata = ref_mem[m_addr];
        if (m_active && !m_wr && cyc == m_ack_cyc) m_dq = m_rdata;
        if (m_active && cyc > m_ack_cyc) m_active = 1'b0;
        if (cyc == m_next) begin
            bc = 1'b0;
`ifdef DMEM_ARB_BROADCAST_EN
            bc = (bus.req == 4'b1111) && (bus.wren == 4'b0000);
            for (int k = 1; k < NC; k++)
                if (8'(bus.Address >> (8 * k)) != 8'(bus.Address)) bc = 1'b0;
`endif
            w = -1;
            for (int k = 0; k < NC; k++) begin
                int j;
                j = (m_p + k) % NC;
                if (w < 0 && ((bus.req >> j) & 4'b0001) != 4'b0000) w = j;
            end
            if (bc) begin
                m_grant = 4'b1111;
                m_wr    = 1'b0;
                m_addr  = 8'(bus.Address);
                m_din   = 8'(bus.Din);
            end else if (w >= 0) begin
                m_grant = 4'b0001 << w;
                m_wr    = ((bus.wren >> w) & 4'b0001) != 4'b0000;
                m_addr  = 8'(bus.Address >> (8 * w));
                m_din   = 8'(bus.Din >> (8 * w));
                m_p     = (w + 1) % NC;
            end
            if (bc || w >= 0) begin
                m_active  = 1'b1;
                m_start   = cyc;
                m_ack_cyc = cyc + (m_wr ? 1 : 2);
                m_next    = m_ack_cyc + 2;
            end else begin
                m_next = cyc + 1;
            end
        end
    endtask

    task automatic check_outputs();
        bit act;
        act = m_active;
        check("grant", bus.grant, act ? m_grant : 4'b0000);
        check("ack", bus.ack, (act && cyc == m_ack_cyc) ? m_grant : 4'b0000);
        check("busy", bus.busy, act);
        check("RAMwren", bus.RAMwren, act && m_wr && cyc == m_start);
        check("RAMAddress", bus.RAMAddress, act ? m_addr : 8'h00);
        check("RAMDin", bus.RAMDin, act ? m_din : 8'h00);
        check("Dq", bus.Dq, m_dq);
    endtask

    task automatic drive_cores();
        for (int i = 0; i < NC; i++) begin
            if (bus.ack[i]) begin
                bus.req[i] = 1'b0;
            end else if (!bus.req[i] && rate_req > 0 && $urandom_range(99) < rate_req) begin
                bus.wren[i]           = ($urandom_range(99) < rate_wr);
                bus.Address[8*i +: 8] = 8'($urandom_range(span - 1));
                bus.Din[8*i +: 8]     = 8'($urandom);
                bus.req[i]            = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        drive_cores();
    endtask

    task automatic issue(input int core, input bit wr, input logic [7:0] addr, input logic [7:0] din);
        bus.wren[core]           = wr;
        bus.Address[8*core +: 8] = addr;
        bus.Din[8*core +: 8]     = din;
        bus.req[core]            = 1'b1;
    endtask

    task automatic wait_ack(input string tag, input logic [NC-1:0] exp_ack,
                            input logic [7:0] exp_dq, input int exp_lat);
        int n;
        n = 0;
        while (bus.ack == 4'b0000 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_ack"}, bus.ack, exp_ack);
        check({tag, "_dq"}, bus.Dq, exp_dq);
        check({tag, "_lat"}, n, exp_lat);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((bus.req != 4'b0000 || bus.busy) && n < 60) begin
            step();
            n++;
        end
        check({tag, "_drain"}, (n < 60), 1'b1);
    endtask

    task automatic do_reset();
        bus.req = '0;
        rstn    = 1'b0;
        model_reset();
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        int            q_order[$];
        int            nack;
        logic [NC-1:0] uni;

        bus.req     = '0;
        bus.wren    = '0;
        bus.Address = '0;
        bus.Din     = '0;
        rstn        = 1'b0;
        fill_en     = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        model_reset();
        step();
        fill_en = 1'b0;
        step();
        check("rst_grant", bus.grant, 4'b0000);
        check("rst_dq", bus.Dq, 8'h00);
        rstn = 1'b1;
        step();

        // Single read: core 2 reads 0x15
        issue(2, 1'b0, 8'h15, 8'h00);
        step();
        check("rd_addr_access", bus.RAMAddress, 8'h15);
        wait_ack("rd", 4'b0100, 8'h5A, 2);
        step();
        check("rd_idle_grant", bus.grant, 4'b0000);

        // Single write: core 1 writes 0xC3 to 0x07
        issue(1, 1'b1, 8'h07, 8'hC3);
        step();
        check("wr_wren", bus.RAMwren, 1'b1);
        check("wr_addr", bus.RAMAddress, 8'h07);
        check("wr_din", bus.RAMDin, 8'hC3);
        wait_ack("wr", 4'b0010, 8'h5A, 1);
        check("wr_wren_low", bus.RAMwren, 1'b0);
        step();

        // Read back the written byte through core 0
        issue(0, 1'b0, 8'h07, 8'h00);
        wait_ack("rdback", 4'b0001, 8'hC3, 3);
        step();

        // Core 3 drops req and changes address while in WAIT
        issue(3, 1'b0, 8'h21, 8'h00);
        step();
        step();
        bus.req[3]          = 1'b0;
        bus.Address[24 +: 8] = 8'h44;
        wait_ack("disturb", 4'b1000, init_val(33), 1);
        step();

        // Async reset during the ACCESS cycle of a write
        issue(1, 1'b1, 8'h30, 8'hEE);
        step();
        check("rstmid_wren_before", bus.RAMwren, 1'b1);
        rstn = 1'b0;
        model_reset();
        #1;
        check("rstmid_wren", bus.RAMwren, 1'b0);
        check("rstmid_grant", bus.grant, 4'b0000);
        bus.req = '0;
        step();
        step();
        rstn = 1'b1;
        issue(0, 1'b0, 8'h31, 8'h00);
        issue(2, 1'b0, 8'h32, 8'h00);
        step();
        check("rstmid_first_grant", bus.grant, 4'b0001);
        drain("rstmid");
        issue(1, 1'b0, 8'h30, 8'h00);
        wait_ack("rstmid_nowrite", 4'b0010, init_val(48), 3);
        step();

        // Contention: all cores read continuously from pointer 0
        do_reset();
        rate_req = 100;
        rate_wr  = 0;
        span     = 64;
        for (int i = 0; i < NC; i++) issue(i, 1'b0, 8'(i * 5), 8'h00);
        for (int s = 0; s < 20; s++) begin
            step();
            for (int k = 0; k < NC; k++)
                if (bus.ack[k]) q_order.push_back(k);
        end
        check("cont_count", q_order.size(), 5);
        for (int k = 0; k < 5; k++) check("cont_order", q_order[k], k % NC);
        rate_req = 0;
        drain("cont");

        // All cores read 0x20 at once
        nack = 0;
        uni  = '0;
        for (int i = 0; i < NC; i++) issue(i, 1'b0, 8'h20, 8'h00);
        for (int s = 0; s < 24; s++) begin
            step();
            if (bus.ack != 4'b0000) begin
                nack++;
                uni = uni | bus.ack;
                check("bc_dq", bus.Dq, 8'h99);
            end
        end
`ifdef DMEM_ARB_BROADCAST_EN
        check("bc_nack", nack, 1);
`else
        check("bc_nack", nack, 4);
`endif
        check("bc_union", uni, 4'b1111);
        drain("bc");

        // Random mixed traffic
        rate_req = 30;
        rate_wr  = 40;
        span     = 16;
        for (int s = 0; s < 400; s++) step();
        rate_req = 0;
        drain("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
